// File: rtl/adc_frame_responder.sv
// Serial ADC stand-in: answers adc_conv/adc_clk with 16-bit frames {2'b00, sample, 2'b00}.
// Define ADC_EMU_TRIANGLE_EN for a triangle-wave generator; the default is a sawtooth.
module adc_frame_responder #(
  parameter logic [11:0] STEP        = 12'd16,
  parameter logic [11:0] START_VALUE = 12'd0
) (
  input  logic        osc_clk,
  input  logic        reset_n,
  input  logic        adc_clk,
  input  logic        adc_conv,
  output logic        adc_data,
  output logic        busy,
  output logic        frame_done,
  output logic [11:0] sample_out
);

  // Handshake: a falling edge of adc_conv starts a frame, each falling edge of
  // adc_clk presents the next bit for the receiver's rising edge, and a rising
  // edge of adc_conv while shifting aborts the frame without advancing the sample.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [1:0]  clk_sync;
  logic [1:0]  conv_sync;
  logic        clk_prev;
  logic        conv_prev;
  logic [15:0] shreg;
  logic [3:0]  idx;
  logic [11:0] sample;
  logic [11:0] next_sample;
  logic [15:0] load_word;
  logic        clk_fall;
  logic        conv_fall;
  logic        conv_rise;
  logic        abort;
  logic        advance;

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b00;
      conv_sync <= 2'b00;
      clk_prev  <= 1'b0;
      conv_prev <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], adc_clk};
      conv_sync <= {conv_sync[0], adc_conv};
      clk_prev  <= clk_sync[1];
      conv_prev <= conv_sync[1];
    end
  end

  assign clk_fall  = clk_prev & ~clk_sync[1];
  assign conv_fall = conv_prev & ~conv_sync[1];
  assign conv_rise = ~conv_prev & conv_sync[1];

  // Abort takes priority over a coincident adc_clk falling edge.
  assign abort     = (state == SHIFT) && conv_rise;
  assign advance   = (state == SHIFT) && !conv_rise && clk_fall && (idx == 4'd0);
  assign load_word = {2'b00, sample, 2'b00};

`ifdef ADC_EMU_TRIANGLE_EN
  logic        dir_down;
  logic        next_dir_down;
  logic [12:0] up_sum;

  assign up_sum = {1'b0, sample} + {1'b0, STEP};

  always_comb begin
    next_sample   = sample;
    next_dir_down = dir_down;
    if (!dir_down) begin
      if (up_sum >= 13'd4095) begin
        next_sample   = 12'hFFF;
        next_dir_down = 1'b1;
      end else begin
        next_sample = up_sum[11:0];
      end
    end else begin
      if (sample <= STEP) begin
        next_sample   = 12'h000;
        next_dir_down = 1'b0;
      end else begin
        next_sample = sample - STEP;
      end
    end
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_down <= 1'b0;
    end else if (advance) begin
      dir_down <= next_dir_down;
    end
  end
`else
  assign next_sample = sample + STEP;
`endif

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= 16'h0000;
      idx        <= 4'd0;
      adc_data   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sample     <= START_VALUE;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          adc_data <= 1'b0;
          if (conv_fall) begin
            shreg    <= load_word;
            adc_data <= load_word[15];
            idx      <= 4'd15;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            adc_data <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (advance) begin
            frame_done <= 1'b1;
            sample     <= next_sample;
            adc_data   <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (clk_fall) begin
            shreg    <= {shreg[14:0], 1'b0};
            adc_data <= shreg[14];
            idx      <= idx - 4'd1;
          end
        end
        default: begin
          adc_data <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign sample_out = sample;

endmodule

// File: tb/tb_adc_frame_responder.sv
// Randomized bench for adc_frame_responder: two instances (different start values)
// driven by one capture-side model, checked against a behavioural sample/frame model.
module tb_adc_frame_responder;

  localparam int          STEP_V  = 16;
  localparam logic [11:0] START_A = 12'h5A3;
  localparam logic [11:0] START_B = 12'hFF8;

  logic        osc_clk = 1'b0;
  logic        reset_n;
  logic        adc_clk;
  logic        adc_conv;
  logic        adc_data   [2];
  logic        busy       [2];
  logic        frame_done [2];
  logic [11:0] sample_out [2];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt [2] = '{0, 0};
  bit          busy_seen = 1'b0;
  logic [15:0] cap [2];
  logic [15:0] exp_q [$];
  int          m_s [2];
  bit          m_down [2];

  adc_frame_responder #(.STEP(12'(STEP_V)), .START_VALUE(START_A)) dut_a (
    .osc_clk(osc_clk), .reset_n(reset_n), .adc_clk(adc_clk), .adc_conv(adc_conv),
    .adc_data(adc_data[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .sample_out(sample_out[0])
  );

  adc_frame_responder #(.STEP(12'(STEP_V)), .START_VALUE(START_B)) dut_b (
    .osc_clk(osc_clk), .reset_n(reset_n), .adc_clk(adc_clk), .adc_conv(adc_conv),
    .adc_data(adc_data[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .sample_out(sample_out[1])
  );

  always #5 osc_clk = ~osc_clk;

  always @(negedge osc_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (frame_done[k] === 1'b1) done_cnt[k]++;
      if (busy[k] === 1'b1) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s[0] = int'(START_A);
    m_s[1] = int'(START_B);
    m_down[0] = 1'b0;
    m_down[1] = 1'b0;
  endtask

  task automatic model_advance(input int k);
`ifdef ADC_EMU_TRIANGLE_EN
    if (!m_down[k]) begin
      if (m_s[k] + STEP_V >= 4095) begin
        m_s[k] = 4095;
        m_down[k] = 1'b1;
      end else begin
        m_s[k] = m_s[k] + STEP_V;
      end
    end else begin
      if (m_s[k] <= STEP_V) begin
        m_s[k] = 0;
        m_down[k] = 1'b0;
      end else begin
        m_s[k] = m_s[k] - STEP_V;
      end
    end
`else
    m_s[k] = (m_s[k] + STEP_V) % 4096;
`endif
  endtask

  task automatic wait_osc(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  // Receiver sees bits 14..0 of the frame on the rising edges, then the idle 0.
  task automatic start_frame();
    int frame;
    adc_conv = 1'b1;
    wait_osc(4);
    adc_conv = 1'b0;
    wait_osc(4);
    for (int k = 0; k < 2; k++) begin
      check("start_busy", busy[k], 1'b1);
      check("start_bit15", adc_data[k], 1'b0);
      frame = m_s[k] * 4;
      exp_q.push_back(16'((frame * 2) % 65536));
      cap[k] = 16'h0000;
    end
  endtask

  task automatic clock_bits(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      adc_clk = 1'b0;
      wait_osc(half);
      adc_clk = 1'b1;
      for (int k = 0; k < 2; k++) cap[k] = {cap[k][14:0], adc_data[k]};
      wait_osc(half);
    end
  endtask

  task automatic full_frame(input int half);
    int d0 [2];
    d0 = done_cnt;
    start_frame();
    clock_bits(16, half);
    wait_osc(4);
    for (int k = 0; k < 2; k++) begin
      check("frame_bits", cap[k], exp_q.pop_front());
      check("frame_done_once", done_cnt[k] - d0[k], 1);
      check("idle_busy", busy[k], 1'b0);
      check("idle_data", adc_data[k], 1'b0);
      model_advance(k);
      check("sample_next", sample_out[k], m_s[k]);
    end
  endtask

  // Abort after nbits receiver bits; with simul set the abort coincides with an adc_clk fall.
  task automatic abort_frame(input int nbits, input int half, input bit simul);
    int d0 [2];
    logic [15:0] e;
    d0 = done_cnt;
    start_frame();
    clock_bits(nbits, half);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      check("abort_partial", cap[k], e >> (16 - nbits));
    end
    if (simul) adc_clk = 1'b0;
    adc_conv = 1'b1;
    wait_osc(3);
    for (int k = 0; k < 2; k++) begin
      check("abort_busy", busy[k], 1'b0);
      check("abort_data", adc_data[k], 1'b0);
    end
    if (simul) adc_clk = 1'b1;
    wait_osc(half + 4);
    for (int k = 0; k < 2; k++) begin
      check("abort_no_done", done_cnt[k] - d0[k], 0);
      check("abort_sample", sample_out[k], m_s[k]);
    end
  endtask

  task automatic reset_mid_frame();
    start_frame();
    clock_bits(9, 8);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("rst_async_data", adc_data[k], 1'b0);
      check("rst_async_busy", busy[k], 1'b0);
      check("rst_async_done", frame_done[k], 1'b0);
      check("rst_async_sample", sample_out[k], m_s[k]);
    end
    wait_osc(3);
    reset_n = 1'b1;
    wait_osc(4);
    busy_seen = 1'b0;
    clock_bits(16, 6);
    wait_osc(4);
    check("no_conv_no_busy", busy_seen, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    adc_clk  = 1'b1;
    adc_conv = 1'b0;
    model_reset();
    wait_osc(3);
    for (int k = 0; k < 2; k++) begin
      check("reset_data", adc_data[k], 1'b0);
      check("reset_busy", busy[k], 1'b0);
      check("reset_done", frame_done[k], 1'b0);
      check("reset_sample", sample_out[k], m_s[k]);
    end
    reset_n = 1'b1;
    wait_osc(4);

    full_frame(64);
    check("spec_vector_5a3", cap[0], 16'h2D18);
    full_frame(64);
    abort_frame(7, 16, 1'b0);
    full_frame(16);
    abort_frame(15, 8, 1'b1);
    full_frame(8);
    reset_mid_frame();
    full_frame(4);
    full_frame(4);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0)
        abort_frame(int'($urandom_range(1, 15)), int'($urandom_range(4, 12)), 1'($urandom_range(0, 1)));
      else
        full_frame(int'($urandom_range(4, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_responder.md
# adc_frame_responder

Synthesizable stand-in for the ADC at the far end of the oscilloscope's serial ADC link. It answers the FPGA capture logic's `adc_conv` / `adc_clk` handshake by shifting out 16-bit frames on `adc_data`. Each frame carries 2 leading padding zeros, a 12-bit sample (MSB first), then 2 trailing padding zeros. Samples come from an internal deterministic waveform generator, so the capture, FIFO and Pi path can be exercised on hardware with a known pattern and no analog front end.

## Interface
- `STEP`, 16: sample increment per completed frame (1..2047).
- `START_VALUE`, 0: sample value after reset (12-bit).
- `osc_clk` in 1: single system clock; all logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `adc_clk` in 1: serial clock from the capture side, asynchronous to this block and sampled in the `osc_clk` domain.
- `adc_conv` in 1: conversion strobe from the capture side; asynchronous.
- `adc_data` out 1: serial frame bit, MSB first.
- `busy` out 1: high while a frame is being shifted.
- `frame_done` out 1: one-cycle pulse when bit 0 of a frame has been held for its full bit period.
- `sample_out` out 12: sample value currently loaded or being shifted (debug).

## Operation
- **Input synchronization.** `adc_clk` and `adc_conv` each pass through a 2-flop synchronizer, followed by one registered stage for edge detection.
- **State machine:** IDLE, SHIFT.
  - **IDLE.** `adc_data` = 0. A synchronized falling edge of `adc_conv` loads the shift register with {2'b00, sample, 2'b00}, drives bit 15, sets bit index = 15 and goes to SHIFT.
  - **SHIFT.** On each synchronized falling edge of `adc_clk`, shift left one bit and decrement the index, so data is stable for the receiver's rising edge. A falling edge that arrives while the index is 0 ends the frame:
    - pulse `frame_done`;
    - advance the generator;
    - drive `adc_data` = 0;
    - return to IDLE.
  - **New conversion mid-frame.** A synchronized rising edge of `adc_conv` in SHIFT aborts the frame: return to IDLE, `adc_data` = 0, no `frame_done`, and the generator does not advance.
  - **Conv edge in SHIFT.** A synchronized falling edge of `adc_conv` in SHIFT is ignored.
- **Generator, default mode (sawtooth).** `sample` = (`sample` + `STEP`) mod 4096, using 12-bit wrap arithmetic.
- **Sample stability.** `sample` changes only on `frame_done`. `sample_out` always reflects the register.
- **Simultaneous edges.** If an `adc_clk` falling edge and an `adc_conv` rising edge are detected in the same cycle, the abort wins.

## Timing
- **Reset values:** `adc_data` = 0, `busy` = 0, `frame_done` = 0, `sample_out` = `START_VALUE`, state = IDLE. All synchronizers clear.
- **Input-to-output latency.** From an input edge at the pin to the `adc_data` update: 3 `osc_clk` cycles (2 synchronizer stages + 1 registered output). `busy` rises in the same cycle as the first `adc_data` update.
- **Clock ratio.** Each `adc_clk` high and low phase must last at least 4 `osc_clk` cycles; the capture side's divide-by-128 gives 64.
- **`adc_data` is registered.** It never changes except on a detected `adc_clk` falling edge, a frame start, an abort, or reset.
- **Asynchronous reset mid-frame.** Immediately forces the reset values. The next frame starts only after a fresh `adc_conv` falling edge.

## Configuration
- `ADC_EMU_TRIANGLE_EN`:
  - **Defined:** the generator produces a triangle wave. A direction bit (reset = up) selects between two rules:
    - up: `sample` += `STEP`, saturating at 4095, and direction flips when 4095 is reached;
    - down: `sample` −= `STEP`, saturating at 0, and direction flips when 0 is reached.
  - **Undefined:** sawtooth wrap as described in Operation. No direction register exists.

## Test plan
- **Single frame.** Reset with `START_VALUE` = 0x5A3, `osc_clk`:`adc_clk` = 128:1, pulse `adc_conv`, then 16 `adc_clk` cycles → on receiver rising edges sample 0,0,1,0,1,1,0,1,0,0,0,1,1,0,0,0. Then `frame_done` pulses once and `sample_out` = 0x5B3.
- **Sawtooth wrap.** `START_VALUE` = 0xFF8, `STEP` = 16, two full frames → second frame carries 0x008.
- **Abort.** Raise `adc_conv` after 7 bits → `adc_data` = 0 and `busy` = 0 within 3 cycles, no `frame_done`, and the next frame repeats the same sample.
- **Reset mid-frame.** Deassert `reset_n` after 9 bits → all outputs return to reset values asynchronously. Sending `adc_clk` edges without `adc_conv` → no `busy`.
- **Triangle mode.** With `ADC_EMU_TRIANGLE_EN` defined, `START_VALUE` = 4080, `STEP` = 16 → successive frames carry 4080, 4095, 4079, 4063.
- **Minimum clock ratio.** `adc_clk` high/low = 4 `osc_clk` cycles each → all 16 bits are correct with no skipped or duplicated bit.
